// File: rtl/cfg_ctx_pkg.sv
// Shared types and defaults for the configuration context sequencer.
// CFG_CTX_SEQUENCER_PARITY_EN adds the per-channel parity helper.
package cfg_ctx_pkg;

  localparam int unsigned CFG_NUM_CH = 4;
  localparam int unsigned CFG_INST_W = 161;
  localparam int unsigned CFG_DEPTH  = 8;
  localparam int unsigned CFG_LOOP_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

`ifdef CFG_CTX_SEQUENCER_PARITY_EN
  // Words are zero-extended to this width before the reduction.
  localparam int unsigned PAR_MAX_W = 1024;

  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/cfg_ctx_bank.sv
// One channel's context storage: synchronous write, asynchronous read.
// CFG_CTX_SEQUENCER_PARITY_EN adds a stored even-parity bit per context.
module cfg_ctx_bank
  import cfg_ctx_pkg::*;
#(
  parameter int unsigned INST_W = CFG_INST_W,
  parameter int unsigned DEPTH  = CFG_DEPTH,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
`ifdef CFG_CTX_SEQUENCER_PARITY_EN
  ,
  output logic              rpar
`endif
);

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

`ifdef CFG_CTX_SEQUENCER_PARITY_EN
  logic par_mem [DEPTH];

  // Parity is captured alongside the data so later corruption is visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) par_mem[i] <= 1'b0;
    end else if (we) begin
      par_mem[waddr] <= even_par(PAR_MAX_W'(wdata));
    end
  end

  assign rpar = par_mem[raddr];
`endif

endmodule

// File: rtl/cfg_ctx_sequencer.sv
// Context store and windowed playback sequencer feeding the PE array.
// CFG_CTX_SEQUENCER_PARITY_EN enables stored parity and the par_err check.
module cfg_ctx_sequencer
  import cfg_ctx_pkg::*;
#(
  parameter int unsigned NUM_CH = CFG_NUM_CH,
  parameter int unsigned INST_W = CFG_INST_W,
  parameter int unsigned DEPTH  = CFG_DEPTH,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned LOOP_W = CFG_LOOP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [AW-1:0]            wr_addr,
  input  logic [NUM_CH*INST_W-1:0] wr_data,
  input  logic                     start,
  input  logic [AW-1:0]            base,
  input  logic [AW:0]              len,
  input  logic [LOOP_W-1:0]        loops,
  input  logic                     abort,
  input  logic                     stall,
  output logic                     busy,
  output logic                     done,
  output logic                     inst_valid,
  output logic [NUM_CH*INST_W-1:0] inst_out,
  output logic [AW-1:0]            ctx_idx,
  output logic                     par_err
);

  state_t              state;
  logic [AW-1:0]       base_q;
  logic [AW:0]         len_q;
  logic [LOOP_W-1:0]   loops_q;
  logic [AW-1:0]       offset;
  logic [LOOP_W-1:0]   loop_cnt;

  logic                     we_c;
  logic                     accept_c;
  logic                     last_off_c;
  logic                     last_beat_c;
  logic                     start_ok_c;
  logic [AW-1:0]            nxt_off_c;
  logic [AW-1:0]            rd_addr_c;
  logic [NUM_CH*INST_W-1:0] rd_data_c;

  assign we_c        = wr_valid & wr_ready;
  assign accept_c    = inst_valid & ~stall;
  assign last_off_c  = ({1'b0, offset} == (len_q - (AW+1)'(1)));
  assign last_beat_c = last_off_c && (loops_q != '0) &&
                       (loop_cnt == (loops_q - LOOP_W'(1)));
  assign nxt_off_c   = last_off_c ? '0 : (offset + AW'(1));
  assign start_ok_c  = start && (len != '0) && (len <= (AW+1)'(DEPTH));
  // In IDLE the read port looks ahead at the first context of a new window.
  assign rd_addr_c   = (state == IDLE) ? base : (base_q + nxt_off_c);

`ifdef CFG_CTX_SEQUENCER_PARITY_EN
  logic [NUM_CH-1:0] rd_par_c;
  logic [NUM_CH-1:0] par_q;
  logic              par_err_q;
  logic              par_bad_c;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cfg_ctx_bank #(
      .INST_W(INST_W),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_bank (
      .clk  (clk),
      .rst  (rst),
      .we   (we_c),
      .waddr(wr_addr),
      .wdata(wr_data[c*INST_W +: INST_W]),
      .raddr(rd_addr_c),
      .rdata(rd_data_c[c*INST_W +: INST_W])
`ifdef CFG_CTX_SEQUENCER_PARITY_EN
      ,
      .rpar (rd_par_c[c])
`endif
    );
  end

`ifdef CFG_CTX_SEQUENCER_PARITY_EN
  // Recheck the beat currently presented against the parity read with it.
  always_comb begin
    par_bad_c = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      par_bad_c = par_bad_c | (inst_valid & ((^inst_out[c*INST_W +: INST_W]) != par_q[c]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q     <= '0;
      par_err_q <= 1'b0;
    end else begin
      if (par_bad_c) par_err_q <= 1'b1;
      if (state == IDLE && start_ok_c) begin
        par_err_q <= 1'b0;
        par_q     <= rd_par_c;
      end else if (state == RUN && !abort && accept_c && !last_beat_c) begin
        par_q <= rd_par_c;
      end
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      loops_q    <= '0;
      offset     <= '0;
      loop_cnt   <= '0;
      wr_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      ctx_idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          wr_ready <= 1'b1;
          if (start_ok_c) begin
            state      <= RUN;
            base_q     <= base;
            len_q      <= len;
            loops_q    <= loops;
            offset     <= '0;
            loop_cnt   <= '0;
            wr_ready   <= 1'b0;
            busy       <= 1'b1;
            inst_valid <= 1'b1;
            inst_out   <= rd_data_c;
            ctx_idx    <= base;
          end
        end
        RUN: begin
          if (abort || (accept_c && last_beat_c)) begin
            state      <= IDLE;
            wr_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= ~abort;
            inst_valid <= 1'b0;
            inst_out   <= '0;
            ctx_idx    <= '0;
          end else if (accept_c) begin
            offset   <= nxt_off_c;
            if (last_off_c) loop_cnt <= loop_cnt + LOOP_W'(1);
            inst_out <= rd_data_c;
            ctx_idx  <= rd_addr_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_ctx_sequencer.sv
// Randomized self-checking bench for cfg_ctx_sequencer against a window/loop model.
module tb_cfg_ctx_sequencer;

  localparam int NCH = 4;
  localparam int IW  = 161;
  localparam int D   = 8;
  localparam int AW  = 3;
  localparam int LW  = 8;
  localparam int DW  = NCH * IW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic [LW-1:0] loops = '0;
  logic          abort = 1'b0;
  logic          stall = 1'b0;
  logic          busy, done, inst_valid, par_err;
  logic [DW-1:0] inst_out;
  logic [AW-1:0] ctx_idx;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [D];
  int            q_idx[$];
  logic [DW-1:0] q_dat[$];
  int            e_idx[$];
  int            n_done;
  bit            timed_out;

  cfg_ctx_sequencer dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .base(base),
    .len(len), .loops(loops), .abort(abort), .stall(stall), .busy(busy),
    .done(done), .inst_valid(inst_valid), .inst_out(inst_out),
    .ctx_idx(ctx_idx), .par_err(par_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] pat(input int ctx);
    logic [DW-1:0] d = '0;
    for (int c = 0; c < NCH; c++) d[c*IW +: IW] = IW'(16'(ctx * 256 + c));
    return d;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d = '0;
    for (int i = 0; i < (DW + 31) / 32; i++) d = {d[DW-33:0], 32'($urandom())};
    return d;
  endfunction

  // Expected context order: window offsets repeated loop after loop, wrapping mod D.
  function automatic void exp_seq(input int b, input int l, input int lp, input int max_n);
    int total = (lp == 0) ? max_n : l * lp;
    e_idx.delete();
    for (int k = 0; k < total && k < max_n; k++) e_idx.push_back((b + (k % l)) % D);
  endfunction

  task automatic write_ctx(input int a, input logic [DW-1:0] d, input bit commit);
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = AW'(a); wr_data = d;
    checks++;
    if (wr_ready !== commit) begin
      errors++; $display("FAIL wr_ready_write: got %b exp %b", wr_ready, commit);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    if (commit) model_mem[a] = d;
  endtask

  task automatic start_cmd(input int b, input int l, input int lp);
    @(negedge clk);
    start = 1'b1; base = AW'(b); len = (AW+1)'(l); loops = LW'(lp);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives stall/abort and records every beat that the next edge will accept.
  task automatic collect(input int stall_pct, input int abort_after, input int budget);
    int acc = 0;
    int cyc = 0;
    q_idx.delete(); q_dat.delete(); n_done = 0; timed_out = 1'b0;
    while (1) begin
      if (done) n_done++;
      if (!busy) break;
      if (cyc >= budget) begin timed_out = 1'b1; break; end
      stall = (int'($urandom_range(99)) < stall_pct);
      abort = (abort_after >= 0 && acc == abort_after);
      if (inst_valid && !stall && !abort) begin
        q_idx.push_back(int'(ctx_idx)); q_dat.push_back(inst_out); acc++;
      end
      @(negedge clk); cyc++;
    end
    stall = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < D; i++) model_mem[i] = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({wr_ready, busy, done, inst_valid, par_err} !== 5'b0 || inst_out !== '0 || ctx_idx !== '0) begin
      errors++; $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b v=%b idx=%0d", wr_ready, busy, done, inst_valid, ctx_idx);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b exp 1", wr_ready); end
  endtask

  task automatic test_load_play();
    for (int i = 0; i < D; i++) write_ctx(i, pat(i), 1'b1);
    start_cmd(0, 8, 1);
    checks++;
    if (busy !== 1'b1 || inst_valid !== 1'b1 || ctx_idx !== 3'd0 || inst_out !== model_mem[0]) begin
      errors++; $display("FAIL start_latency: got busy=%b v=%b idx=%0d exp 1 1 0", busy, inst_valid, ctx_idx);
    end
    collect(0, -1, 50);
    exp_seq(0, 8, 1, 100);
    checks++;
    if (q_idx.size() != e_idx.size() || n_done != 1 || timed_out) begin
      errors++; $display("FAIL load_play_count: got %0d beats %0d done exp %0d 1", q_idx.size(), n_done, e_idx.size());
    end
    for (int i = 0; i < q_idx.size() && i < e_idx.size(); i++) begin
      checks++;
      if (q_idx[i] != e_idx[i] || q_dat[i] !== model_mem[e_idx[i]]) begin
        errors++; $display("FAIL load_play_beat%0d: got idx %0d exp %0d", i, q_idx[i], e_idx[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL done_pulse_width: got done=%b busy=%b rdy=%b exp 0 0 1", done, busy, wr_ready);
    end
  endtask

  task automatic test_wrap_loops();
    start_cmd(6, 4, 2);
    collect(0, -1, 50);
    exp_seq(6, 4, 2, 100);
    checks++;
    if (q_idx.size() != 8 || n_done != 1) begin
      errors++; $display("FAIL wrap_count: got %0d beats %0d done exp 8 1", q_idx.size(), n_done);
    end
    for (int i = 0; i < q_idx.size() && i < e_idx.size(); i++) begin
      checks++;
      if (q_idx[i] != e_idx[i] || q_dat[i] !== model_mem[e_idx[i]]) begin
        errors++; $display("FAIL wrap_beat%0d: got idx %0d exp %0d", i, q_idx[i], e_idx[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] snap;
    int guard = 0;
    start_cmd(0, 8, 1);
    while (ctx_idx !== 3'd2 && guard < 20) begin @(negedge clk); guard++; end
    snap = inst_out;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (inst_out !== snap || ctx_idx !== 3'd2 || inst_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d: got idx %0d v=%b exp 2 1", k, ctx_idx, inst_valid);
      end
    end
    stall = 1'b0;
    collect(0, -1, 50);
    exp_seq(2, 6, 1, 100);
    checks++;
    if (q_idx.size() != 6 || n_done != 1) begin
      errors++; $display("FAIL stall_count: got %0d beats exp 6", q_idx.size());
    end
    for (int i = 0; i < q_idx.size() && i < e_idx.size(); i++) begin
      checks++;
      if (q_idx[i] != e_idx[i] || q_dat[i] !== model_mem[e_idx[i]]) begin
        errors++; $display("FAIL stall_beat%0d: got idx %0d exp %0d", i, q_idx[i], e_idx[i]);
      end
    end
  endtask

  task automatic test_abort_infinite();
    int b = int'($urandom_range(D - 1));
    int l = int'($urandom_range(D, 1));
    start_cmd(b, l, 0);
    collect(25, 13, 400);
    exp_seq(b, l, 0, 13);
    checks++;
    if (q_idx.size() != 13 || n_done != 0 || timed_out) begin
      errors++; $display("FAIL abort_count: got %0d beats %0d done exp 13 0", q_idx.size(), n_done);
    end
    for (int i = 0; i < q_idx.size() && i < e_idx.size(); i++) begin
      checks++;
      if (q_idx[i] != e_idx[i] || q_dat[i] !== model_mem[e_idx[i]]) begin
        errors++; $display("FAIL abort_beat%0d: got idx %0d exp %0d", i, q_idx[i], e_idx[i]);
      end
    end
    checks++;
    if (inst_valid !== 1'b0 || inst_out !== '0 || wr_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL abort_state: got v=%b rdy=%b done=%b exp 0 1 0", inst_valid, wr_ready, done);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got rdy=%b busy=%b done=%b exp 1 0 0", wr_ready, busy, done);
    end
  endtask

  task automatic test_illegal_overlap();
    start_cmd(0, 0, 1);
    checks++;
    if (busy !== 1'b0 || inst_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL illegal_len0: got busy=%b v=%b done=%b exp 0 0 0", busy, inst_valid, done);
    end
    start_cmd(0, 9, 1);
    checks++;
    if (busy !== 1'b0 || inst_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL illegal_len9: got busy=%b v=%b done=%b exp 0 0 0", busy, inst_valid, done);
    end
    start_cmd(0, 8, 2);
    stall = 1'b1; wr_valid = 1'b1; wr_addr = 3'd0; wr_data = rand_data();
    start = 1'b1; base = 3'd5; len = 4'd2; loops = 8'd1;
    checks++;
    if (wr_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL run_wr_ready: got rdy=%b busy=%b exp 0 1", wr_ready, busy);
    end
    @(negedge clk);
    wr_valid = 1'b0; start = 1'b0; stall = 1'b0;
    collect(20, -1, 200);
    exp_seq(0, 8, 2, 100);
    checks++;
    if (q_idx.size() != 16 || n_done != 1) begin
      errors++; $display("FAIL overlap_count: got %0d beats %0d done exp 16 1", q_idx.size(), n_done);
    end
    for (int i = 0; i < q_idx.size() && i < e_idx.size(); i++) begin
      checks++;
      if (q_idx[i] != e_idx[i] || q_dat[i] !== model_mem[e_idx[i]]) begin
        errors++; $display("FAIL overlap_beat%0d: got idx %0d exp %0d", i, q_idx[i], e_idx[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int b, l, lp;
      for (int w = 0; w < 3; w++) write_ctx(int'($urandom_range(D - 1)), rand_data(), 1'b1);
      b = int'($urandom_range(D - 1)); l = int'($urandom_range(D, 1)); lp = int'($urandom_range(3, 1));
      start_cmd(b, l, lp);
      collect(30, -1, 500);
      exp_seq(b, l, lp, 100);
      checks++;
      if (q_idx.size() != e_idx.size() || n_done != 1 || timed_out) begin
        errors++; $display("FAIL random%0d_count: got %0d beats %0d done exp %0d 1", it, q_idx.size(), n_done, e_idx.size());
      end
      for (int i = 0; i < q_idx.size() && i < e_idx.size(); i++) begin
        checks++;
        if (q_idx[i] != e_idx[i] || q_dat[i] !== model_mem[e_idx[i]]) begin
          errors++; $display("FAIL random%0d_beat%0d: got idx %0d exp %0d", it, i, q_idx[i], e_idx[i]);
        end
      end
    end
`ifndef CFG_CTX_SEQUENCER_PARITY_EN
    checks++;
    if (par_err !== 1'b0) begin errors++; $display("FAIL par_err_tied: got %b exp 0", par_err); end
`endif
  endtask

  task automatic test_reset_mid_run();
    start_cmd(3, 8, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({wr_ready, busy, done, inst_valid} !== 4'b0 || inst_out !== '0 || ctx_idx !== '0) begin
      errors++; $display("FAIL reset_mid_run: got rdy=%b busy=%b v=%b idx=%0d exp all 0", wr_ready, busy, inst_valid, ctx_idx);
    end
    for (int i = 0; i < D; i++) model_mem[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    start_cmd(0, 8, 1);
    collect(0, -1, 50);
    checks++;
    if (q_idx.size() != 8 || n_done != 1) begin
      errors++; $display("FAIL reset_clear_count: got %0d beats exp 8", q_idx.size());
    end
    for (int i = 0; i < q_idx.size(); i++) begin
      checks++;
      if (q_dat[i] !== model_mem[i] || q_idx[i] != i) begin
        errors++; $display("FAIL reset_clear_beat%0d: got idx %0d exp %0d nonzero data", i, q_idx[i], i);
      end
    end
  endtask

`ifdef CFG_CTX_SEQUENCER_PARITY_EN
  task automatic test_parity();
    for (int i = 0; i < D; i++) write_ctx(i, pat(i) | rand_data(), 1'b1);
    @(negedge clk);
    dut.g_ch[1].u_bank.mem[3][5] = ~dut.g_ch[1].u_bank.mem[3][5];
    model_mem[3][IW+5] = ~model_mem[3][IW+5];
    start_cmd(0, 2, 1);
    collect(0, -1, 50);
    checks++;
    if (par_err !== 1'b0) begin errors++; $display("FAIL parity_clean: got %b exp 0", par_err); end
    start_cmd(2, 3, 1);
    collect(0, -1, 50);
    checks++;
    if (q_idx.size() != 3 || q_dat.size() < 2 || q_dat[1] !== model_mem[3]) begin
      errors++; $display("FAIL parity_play: got %0d beats exp 3 with flipped ctx3", q_idx.size());
    end
    @(negedge clk);
    checks++;
    if (par_err !== 1'b1) begin errors++; $display("FAIL parity_sticky: got %b exp 1", par_err); end
    start_cmd(5, 2, 1);
    checks++;
    if (par_err !== 1'b0) begin errors++; $display("FAIL parity_clear: got %b exp 0", par_err); end
    collect(0, -1, 50);
    checks++;
    if (par_err !== 1'b0) begin errors++; $display("FAIL parity_after_clear: got %b exp 0", par_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_play();
    test_wrap_loops();
    test_stall();
    test_abort_infinite();
    test_illegal_overlap();
    test_random();
    test_reset_mid_run();
`ifdef CFG_CTX_SEQUENCER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_ctx_sequencer.md
# cfg_ctx_sequencer

Multi-channel configuration context store and playback sequencer for the PE array. It holds DEPTH contexts, each with NUM_CH instruction words of INST_W bits. Contexts are loaded through a valid/ready write port while the block is idle. On command, the block replays a contiguous window of contexts for a programmed number of loops, presenting one registered context per beat under consumer back-pressure. It sits between the host configuration loader and the PE-array instruction inputs.

## Interface
Parameters:
- NUM_CH, 4: number of instruction channels (PE groups).
- INST_W, 161: instruction word width per channel.
- DEPTH, 8: number of contexts; must be a power of two and ≥2.
- AW, $clog2(DEPTH): context address width.
- LOOP_W, 8: width of the loop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- wr_valid  in  1  context write request.
- wr_ready  out  1  write accepted; high only in IDLE.
- wr_addr  in  AW  target context.
- wr_data  in  NUM_CH*INST_W  channel c occupies bits [c*INST_W +: INST_W].
- start  in  1  begin playback; sampled only in IDLE.
- base  in  AW  first context of the window.
- len  in  AW+1  window length in contexts, legal range 1..DEPTH.
- loops  in  LOOP_W  window repetitions; 0 means repeat until abort.
- abort  in  1  terminate playback.
- stall  in  1  consumer not ready; holds the output beat.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on normal completion.
- inst_valid  out  1  inst_out carries a context.
- inst_out  out  NUM_CH*INST_W  registered context; all zero when inst_valid=0.
- ctx_idx  out  AW  address of the context on inst_out.
- par_err  out  1  sticky parity error flag; see Configuration.

## Operation
- FSM has two states: IDLE and RUN.
- Write: a write commits in any cycle where wr_valid && wr_ready. All NUM_CH words are written to wr_addr in that edge.
- Write while RUN: wr_ready=0, so the write is held off. Memory is never modified during playback.
- Start: in IDLE, start with 1≤len≤DEPTH moves the FSM to RUN. It latches base, len and loops, and clears offset and loop count.
  - Illegal start (len=0 or len>DEPTH) is ignored: FSM stays IDLE, no done.
  - start asserted in RUN is ignored.
- Read address is (base+offset) mod DEPTH, so a window may wrap past DEPTH-1 to 0.
- Beat acceptance: a beat is accepted when inst_valid=1 and stall=0 at a clock edge.
  - On acceptance, offset advances.
  - At offset=len-1 the offset wraps to 0 and the loop count increments.
- Last beat: the beat at offset len-1 on loop loops-1 (loops≠0).
  - When it is accepted, the FSM returns to IDLE.
  - Next cycle: inst_valid=0 and done=1 for exactly one cycle.
- Infinite mode (loops=0) never completes by itself.
- Abort in RUN takes effect at the next edge and overrides stall:
  - FSM goes to IDLE and inst_valid goes to 0.
  - done is not asserted.
- Abort in IDLE has no effect.

## Timing
- Reset values:
  - Every context word is cleared to 0.
  - FSM in IDLE.
  - wr_ready=0 while rst is high and 1 from the first clock after release.
  - busy=0, done=0, inst_valid=0, inst_out=0, ctx_idx=0, par_err=0.
- Start latency: start sampled at edge T gives busy=1 and inst_valid=1 with context base after T. First-beat latency is 1 cycle.
- Throughput: with stall=0, one context per cycle with no bubbles, including across window wrap and loop boundaries.
- Stall: inst_out, ctx_idx and inst_valid hold unchanged for as long as stall=1.
- Write-to-read: a context written at edge T is readable by a start sampled at edge T+1 or later.
- Reset mid-RUN: asynchronous return to IDLE with all outputs at their reset values and memory cleared.

## Configuration
- Macro: CFG_CTX_SEQUENCER_PARITY_EN.
- Defined:
  - One even-parity bit is stored per channel per context and computed at write time.
  - Each issued beat is rechecked against its stored parity.
  - Any mismatch sets par_err, which stays set until reset or the next accepted start.
- Undefined:
  - No parity storage is built.
  - par_err is tied to 0 and the port is still present.

## Structure
- Package cfg_ctx_pkg holds:
  - The FSM state enum (IDLE, RUN).
  - Default values for NUM_CH, INST_W, DEPTH and LOOP_W.
  - A parity function, built only under the macro.
- Sub-module cfg_ctx_bank: one channel's DEPTH×INST_W storage with synchronous write, asynchronous read and optional parity bit.
  - Instantiated NUM_CH times by generate.
  - The sequencer FSM and output register live in the top level.

## Test plan
- Reset then load: write contexts 0..7 with channel c = {ctx, c} pattern; start base=0, len=8, loops=1 -> 8 consecutive beats ctx 0..7, then done pulse, then IDLE.
- Wrap and loops: base=6, len=4, loops=2 -> ctx_idx sequence 6,7,0,1,6,7,0,1, then done.
- Stall: assert stall for 3 cycles on the beat with ctx_idx=2 -> inst_out held for 4 cycles, no context skipped or repeated.
- Abort in infinite mode: loops=0, abort after 13 beats -> inst_valid=0 on the next cycle, done never asserted, wr_ready=1.
- Illegal and overlapping commands: start with len=0 -> stays IDLE; start during RUN and wr_valid during RUN -> ignored, memory unchanged.
- Parity (macro defined): force a stored bit flip in channel 1, context 3, then play it back -> par_err=1, sticky until the next start.
